// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and memory-port signals of the instruction memory arbiter.
interface imem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          flush_fetch;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;
  logic          busy;
  logic          timeout_err;
  modport slave (
    input  f_req, f_addr, flush_fetch, l_req, l_we, l_addr, l_wdata, m_ack, m_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_req, m_we, m_addr, m_wdata,
           busy, timeout_err
  );
  modport master (
    output f_req, f_addr, flush_fetch, l_req, l_we, l_addr, l_wdata, m_ack, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, m_req, m_we, m_addr, m_wdata,
           busy, timeout_err
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction memory port between fetch and loader, with ack timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise the loader always beats fetch.
module imem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  imem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, BUSY_F = 2'd1, BUSY_L = 2'd2;
  localparam logic [DW-1:0] NOP = DW'(32'h13);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT);
  logic [1:0] state;
  logic [15:0] cnt;
  logic flushed, f_ok, pick_l, done;
  assign f_ok = bus.f_req && !bus.flush_fetch;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_l;
  assign pick_l = bus.l_req && !(f_ok && last_l);
`else
  assign pick_l = bus.l_req;
`endif
  // ack and timeout may coincide; the ack data takes precedence below
  assign done = state != IDLE && (bus.m_ack || cnt + 16'd1 == LIMIT);
  assign bus.busy = state != IDLE;
  assign bus.m_req = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      flushed <= 1'b0;
      bus.f_gnt <= 1'b0;
      bus.l_gnt <= 1'b0;
      bus.f_rvalid <= 1'b0;
      bus.l_rvalid <= 1'b0;
      bus.f_rdata <= '0;
      bus.l_rdata <= '0;
      bus.m_we <= 1'b0;
      bus.m_addr <= {AW{1'b0}};
      bus.m_wdata <= '0;
      bus.timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_l <= 1'b0;
`endif
    end else begin
      bus.f_gnt <= 1'b0;
      bus.l_gnt <= 1'b0;
      bus.f_rvalid <= 1'b0;
      bus.l_rvalid <= 1'b0;
      if (state == IDLE) begin
        if (pick_l || f_ok) begin
          state <= pick_l ? BUSY_L : BUSY_F;
          bus.l_gnt <= pick_l;
          bus.f_gnt <= !pick_l;
          bus.m_we <= pick_l && bus.l_we;
          bus.m_addr <= pick_l ? bus.l_addr : bus.f_addr;
          bus.m_wdata <= pick_l ? bus.l_wdata : '0;
          cnt <= '0;
          flushed <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
          last_l <= pick_l;
`endif
        end
      end else if (done) begin
        state <= IDLE;
        bus.m_we <= 1'b0;
        if (!bus.m_ack) bus.timeout_err <= 1'b1;
        if (state == BUSY_L) begin
          bus.l_rvalid <= 1'b1;
          bus.l_rdata <= (bus.m_ack && !bus.m_we) ? bus.m_rdata : '0;
        end else if (!flushed && !bus.flush_fetch) begin
          bus.f_rvalid <= 1'b1;
          bus.f_rdata <= bus.m_ack ? bus.m_rdata : NOP;
        end
      end else begin
        cnt <= cnt + 16'd1;
        if (bus.flush_fetch) flushed <= 1'b1;
      end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed stimulus, transaction-level model checked every cycle, literal anchors.
module tb_imem_port_arbiter;
  localparam int AW = 32, DW = 32, TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  imem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
  imem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  string gs = "";
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: who owns the port (0 none, 1 fetch, 2 loader) and how many BUSY cycles it has used
  int who = 0, age = 0;
  bit dropped, last_l, terr, we, e_fg, e_lg, e_fv, e_lv;
  logic [31:0] addr, wdata, e_frd, e_lrd;
  always @(posedge clk) begin
    bit f_ok, take_l, ack;
    logic [31:0] rd;
    f_ok = bus.f_req && !bus.flush_fetch;
    ack = bus.m_ack;
    rd = bus.m_rdata;
    e_fg = 0; e_lg = 0; e_fv = 0; e_lv = 0;
    if (!rst) begin
      who = 0; age = 0; terr = 0; e_frd = 0; e_lrd = 0; last_l = 0; dropped = 0; we = 0;
    end else if (who == 0) begin
      if (bus.l_req || f_ok) begin
        take_l = (bus.l_req && f_ok) ? !(RR && last_l) : bus.l_req;
        who = take_l ? 2 : 1;
        addr = take_l ? bus.l_addr : bus.f_addr;
        we = take_l && bus.l_we;
        wdata = bus.l_wdata;
        age = 1; dropped = 0; last_l = take_l;
        e_lg = take_l; e_fg = !take_l;
      end
    end else begin
      if (who == 1 && bus.flush_fetch) dropped = 1;
      if (ack || age == TO) begin
        if (!ack) terr = 1;
        if (who == 2) begin e_lv = 1; e_lrd = (ack && !we) ? rd : 32'h0; end
        else if (!dropped) begin e_fv = 1; e_frd = ack ? rd : 32'h13; end
        who = 0;
      end else age++;
    end
    #1;
    chk("busy", bus.busy, who != 0);
    chk("m_req", bus.m_req, who != 0);
    chk("f_gnt", bus.f_gnt, e_fg);
    chk("l_gnt", bus.l_gnt, e_lg);
    chk("f_rvalid", bus.f_rvalid, e_fv);
    chk("l_rvalid", bus.l_rvalid, e_lv);
    chk("f_rdata", bus.f_rdata, e_frd);
    chk("l_rdata", bus.l_rdata, e_lrd);
    chk("timeout_err", bus.timeout_err, terr);
    if (who != 0) begin
      chk("m_addr", bus.m_addr, addr);
      chk("m_we", bus.m_we, we);
      if (who == 2) chk("m_wdata", bus.m_wdata, wdata);
    end
    if (bus.l_gnt) gs = {gs, "L"};
    if (bus.f_gnt) gs = {gs, "F"};
  end
  task automatic zero_inputs();
    bus.f_req = 0; bus.f_addr = 0; bus.flush_fetch = 0; bus.l_req = 0; bus.l_we = 0;
    bus.l_addr = 0; bus.l_wdata = 0; bus.m_ack = 0; bus.m_rdata = 0;
  endtask
  initial begin
    int n, nv;
    logic [31:0] v;
    string exp_order;
    zero_inputs();
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mreq", bus.m_req, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk("rst_frdata", bus.f_rdata, 0);
    rst = 1;
    // basic fetch with immediate ack
    bus.f_req = 1; bus.f_addr = 32'h10;
    @(negedge clk); bus.f_req = 0;
    chk("t1_fgnt", bus.f_gnt, 1);
    chk("t1_maddr", bus.m_addr, 32'h10);
    bus.m_ack = 1; bus.m_rdata = 32'h00500093;
    @(negedge clk); bus.m_ack = 0;
    chk("t1_frvalid", bus.f_rvalid, 1);
    chk("t1_frdata", bus.f_rdata, 32'h00500093);
    @(negedge clk);
    chk("t1_pulse", bus.f_rvalid, 0);
    chk("t1_hold", bus.f_rdata, 32'h00500093);
    // contention with m_ack held high, also across idle cycles
    gs = "";
    bus.f_req = 1; bus.l_req = 1; bus.f_addr = 32'h100; bus.l_addr = 32'h200;
    bus.m_ack = 1; bus.m_rdata = 32'h11;
    repeat (12) @(negedge clk);
    bus.f_req = 0; bus.l_req = 0; bus.m_ack = 0;
    exp_order = RR ? "LFLF" : "LLLL";
    checks++;
    if (gs.substr(0, 3) != exp_order) begin
      errors++;
      $display("FAIL grant_order: got %s expected %s", gs, exp_order);
    end
    repeat (2) @(negedge clk);
    // loader write, ack on the 4th BUSY cycle (same cycle the wait limit is reached)
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h40; bus.l_wdata = 32'hDEADBEEF; bus.m_rdata = 32'h12345678;
    @(negedge clk); bus.l_req = 0; bus.l_wdata = 0;
    chk("t2_lgnt", bus.l_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.m_ack = 1;
      chk("t2_mwe", bus.m_we, 1);
      chk("t2_mwdata", bus.m_wdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    bus.m_ack = 0;
    chk("t2_lrvalid", bus.l_rvalid, 1);
    chk("t2_lrdata", bus.l_rdata, 0);
    chk("t2_noerr", bus.timeout_err, 0);
    // loader read is unaffected by flush_fetch
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h44;
    @(negedge clk); bus.l_req = 0; bus.flush_fetch = 1; bus.m_ack = 1; bus.m_rdata = 32'hCAFEF00D;
    @(negedge clk); bus.m_ack = 0; bus.flush_fetch = 0;
    chk("t3_lrvalid", bus.l_rvalid, 1);
    chk("t3_lrdata", bus.l_rdata, 32'hCAFEF00D);
    // fetch timeout
    bus.f_req = 1; bus.f_addr = 32'h20;
    @(negedge clk); bus.f_req = 0;
    n = 0; nv = 0; v = 0;
    repeat (8) begin
      n += int'(bus.m_req);
      if (bus.f_rvalid) begin nv++; v = bus.f_rdata; end
      @(negedge clk);
    end
    chk("t4_busy_cycles", n, 4);
    chk("t4_nresp", nv, 1);
    chk("t4_nop", v, 32'h13);
    chk("t4_terr", bus.timeout_err, 1);
    // flush in the middle of a fetch
    bus.f_req = 1; bus.f_addr = 32'h30;
    @(negedge clk); bus.f_req = 0; bus.flush_fetch = 1;
    @(negedge clk); bus.flush_fetch = 0; bus.m_ack = 1; bus.m_rdata = 32'hBAD;
    @(negedge clk); bus.m_ack = 0;
    nv = 0;
    repeat (3) begin nv += int'(bus.f_rvalid); @(negedge clk); end
    chk("t5_flushed", nv, 0);
    chk("t5_hold", bus.f_rdata, 32'h13);
    // flush on the completing edge
    bus.f_req = 1; bus.f_addr = 32'h38;
    @(negedge clk); bus.f_req = 0; bus.m_ack = 1; bus.flush_fetch = 1; bus.m_rdata = 32'hBAD2;
    @(negedge clk); bus.m_ack = 0; bus.flush_fetch = 0;
    chk("t5_edge_flush", bus.f_rvalid, 0);
    // f_req together with flush is ignored
    bus.f_req = 1; bus.flush_fetch = 1;
    @(negedge clk); bus.f_req = 0; bus.flush_fetch = 0;
    chk("t5_ign_gnt", bus.f_gnt, 0);
    chk("t5_ign_busy", bus.busy, 0);
    // next fetch is served normally
    bus.f_req = 1; bus.f_addr = 32'h34;
    @(negedge clk); bus.f_req = 0; bus.m_ack = 1; bus.m_rdata = 32'h00A00113;
    @(negedge clk); bus.m_ack = 0;
    chk("t5_frvalid", bus.f_rvalid, 1);
    chk("t5_frdata", bus.f_rdata, 32'h00A00113);
    chk("t5_sticky", bus.timeout_err, 1);
    // asynchronous reset in the middle of a loader transaction
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h50; bus.l_wdata = 32'h77;
    @(negedge clk); bus.l_req = 0;
    chk("t6_busy", bus.busy, 1);
    #2 rst = 0;
    #1;
    chk("t6_mreq", bus.m_req, 0);
    chk("t6_busy0", bus.busy, 0);
    chk("t6_terr", bus.timeout_err, 0);
    @(negedge clk); rst = 1; bus.m_ack = 1;
    @(negedge clk); bus.m_ack = 0;
    nv = 0;
    repeat (3) begin nv += int'(bus.l_rvalid); @(negedge clk); end
    chk("t6_noresp", nv, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
